// File: rtl/ddr_wr_arb_pkg.sv
// Shared types and helpers for the DDR write-burst arbiter.
package ddr_wr_arb_pkg;

  localparam int unsigned CNT_WD = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Low bit of channel idx inside a flattened bus of wd-wide slices.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned wd);
    return idx * wd;
  endfunction

  // Width of a channel index; never below one bit.
  function automatic int unsigned idx_wd(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb_onehot.sv
// Round-robin pick: first set request at or above ptr, wrapping to bit 0.
module rr_arb_onehot
  import ddr_wr_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned PW = idx_wd(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] masked;

  // Lowest set bit of the requests at/above ptr, else lowest set bit overall.
  always_comb begin
    hi_mask = {N{1'b1}} << ptr;
    masked  = req & hi_mask;
    if (|masked) gnt = masked & (~masked + N'(1));
    else         gnt = req & (~req + N'(1));
  end

endmodule

// File: rtl/ddr_wr_burst_arb.sv
// N-channel round-robin arbiter forwarding one write burst at a time to DDR,
// with per-channel burst statistics, watchdog and beat-count checks.
module ddr_wr_burst_arb
  import ddr_wr_arb_pkg::*;
#(
  parameter int unsigned CH_NUM      = 4,
  parameter int unsigned DDR_ADDR_WD = 32,
  parameter int unsigned DDR_DATA_WD = 512,
  parameter int unsigned LEN_WD      = 10,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                            ddr_clk,
  input  logic                            ddr_rst,
  input  logic                            cfg_rst,
  input  logic [CH_NUM-1:0]               ch_wr_burst_req,
  input  logic [CH_NUM*LEN_WD-1:0]        ch_wr_burst_len,
  input  logic [CH_NUM*DDR_ADDR_WD-1:0]   ch_wr_burst_addr,
  input  logic [CH_NUM*DDR_DATA_WD-1:0]   ch_wr_burst_data,
  output logic [CH_NUM-1:0]               ch_wr_burst_data_req,
  output logic [CH_NUM-1:0]               ch_wr_burst_finish,
  output logic                            wr_burst_req,
  output logic [LEN_WD-1:0]               wr_burst_len,
  output logic [DDR_ADDR_WD-1:0]          wr_burst_addr,
  input  logic                            wr_burst_data_req,
  output logic [DDR_DATA_WD-1:0]          wr_burst_data,
  input  logic                            wr_burst_finish,
  output logic                            arb_busy,
  output logic [CH_NUM*CNT_WD-1:0]        ch_burst_cnt,
  output logic [CH_NUM-1:0]               err_timeout,
  output logic [CH_NUM-1:0]               err_len_mismatch,
  output logic [CH_NUM-1:0]               err_len_zero
);

  localparam int unsigned IW = idx_wd(CH_NUM);
  localparam int unsigned WW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned BW = LEN_WD + 1;
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);

  arb_state_t          state, state_next;
  logic [CH_NUM-1:0]   grant, win;
  logic [IW-1:0]       gidx, win_idx, ptr;
  logic [BW-1:0]       beat_cnt, beat_next;
  logic [WW-1:0]       wd_cnt;
  logic [LEN_WD-1:0]   win_len;
  logic [DDR_ADDR_WD-1:0] win_addr;
  logic [CNT_WD-1:0]   cnt [CH_NUM];
  logic                any_req, in_xfer, fin_ev, to_ev;

  rr_arb_onehot #(.N(CH_NUM)) u_rr (
    .req (ch_wr_burst_req),
    .ptr (ptr),
    .gnt (win)
  );

  assign any_req   = |ch_wr_burst_req;
  assign in_xfer   = (state == REQ) || (state == BURST);
  assign fin_ev    = in_xfer && wr_burst_finish;
  // A finish in the same cycle as the last watchdog tick takes precedence.
  assign to_ev     = in_xfer && !wr_burst_finish && (wd_cnt == WD_LAST);
  assign beat_next = beat_cnt + BW'(wr_burst_data_req);

  assign arb_busy             = (state != IDLE);
  assign wr_burst_req         = (state == REQ);
  assign ch_wr_burst_data_req = {CH_NUM{wr_burst_data_req}} & grant;
  assign ch_wr_burst_finish   = (state == DONE) ? grant : '0;

  // Index and request fields of the current round-robin winner.
  always_comb begin
    win_idx  = '0;
    win_len  = '0;
    win_addr = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (win[i]) begin
        win_idx  = IW'(i);
        win_len  = ch_wr_burst_len[slice_lo(i, LEN_WD) +: LEN_WD];
        win_addr = ch_wr_burst_addr[slice_lo(i, DDR_ADDR_WD) +: DDR_ADDR_WD];
      end
    end
  end

  // Data of the granted channel straight through; zero when nobody owns the port.
  always_comb begin
    wr_burst_data = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (grant[i]) wr_burst_data = ch_wr_burst_data[slice_lo(i, DDR_DATA_WD) +: DDR_DATA_WD];
    end
  end

  // Flatten the per-channel burst counters.
  always_comb begin
    ch_burst_cnt = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      ch_burst_cnt[slice_lo(i, CNT_WD) +: CNT_WD] = cnt[i];
    end
  end

  // State register.
  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = (win_len == '0) ? DONE : REQ;
      REQ: begin
        if (fin_ev || to_ev)        state_next = DONE;
        else if (wr_burst_data_req) state_next = BURST;
      end
      BURST:   if (fin_ev || to_ev) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant, registered burst fields, beat counter, watchdog and rr pointer.
  always_ff @(posedge ddr_clk) begin
    if (ddr_rst) begin
      grant         <= '0;
      gidx          <= '0;
      ptr           <= '0;
      wr_burst_len  <= '0;
      wr_burst_addr <= '0;
      beat_cnt      <= '0;
      wd_cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant         <= win;
            gidx          <= win_idx;
            wr_burst_len  <= win_len;
            wr_burst_addr <= win_addr;
            beat_cnt      <= '0;
            wd_cnt        <= '0;
          end
        end
        REQ, BURST: begin
          beat_cnt <= beat_next;
          wd_cnt   <= wd_cnt + WW'(1);
        end
        DONE: begin
          grant <= '0;
          ptr   <= (gidx == IW'(CH_NUM - 1)) ? '0 : gidx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // Statistics and sticky error flags; cfg_rst overrides any same-cycle update.
  always_ff @(posedge ddr_clk) begin
    if (ddr_rst || cfg_rst) begin
      err_timeout      <= '0;
      err_len_mismatch <= '0;
      err_len_zero     <= '0;
      for (int unsigned i = 0; i < CH_NUM; i++) cnt[i] <= '0;
    end else begin
      if (state == IDLE && any_req && win_len == '0) err_len_zero <= err_len_zero | win;
      if (to_ev) err_timeout <= err_timeout | grant;
      if (fin_ev) begin
        cnt[gidx] <= cnt[gidx] + CNT_WD'(1);
        if (beat_next != {1'b0, wr_burst_len}) err_len_mismatch <= err_len_mismatch | grant;
      end
    end
  end

endmodule

// File: tb/tb_ddr_wr_burst_arb.sv
// Randomized bench for ddr_wr_burst_arb against a transaction-level model.
module tb_ddr_wr_burst_arb;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 10;
  localparam int unsigned TO = 32;

  logic ddr_clk = 1'b0;
  always #5 ddr_clk = ~ddr_clk;

  logic            ddr_rst, cfg_rst;
  logic [N-1:0]    req;
  logic [N*LW-1:0] lenf;
  logic [N*AW-1:0] addrf;
  logic [N*DW-1:0] dataf;
  logic [N-1:0]    ch_dreq, ch_fin;
  logic            wr_req, ctl_dreq, ctl_fin, busy;
  logic [LW-1:0]   wr_len;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [N*32-1:0] bcnt;
  logic [N-1:0]    e_to, e_lm, e_lz;

  logic [LW-1:0] ch_len  [N];
  logic [AW-1:0] ch_addr [N];
  logic [DW-1:0] ch_data [N];

  // Reference model state.
  int unsigned  m_ptr;
  int unsigned  m_cnt [N];
  logic [N-1:0] m_to, m_lm, m_lz;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  ddr_wr_burst_arb #(
    .CH_NUM(N), .DDR_ADDR_WD(AW), .DDR_DATA_WD(DW), .LEN_WD(LW), .TIMEOUT_CYC(TO)
  ) dut (
    .ddr_clk(ddr_clk), .ddr_rst(ddr_rst), .cfg_rst(cfg_rst),
    .ch_wr_burst_req(req), .ch_wr_burst_len(lenf), .ch_wr_burst_addr(addrf),
    .ch_wr_burst_data(dataf), .ch_wr_burst_data_req(ch_dreq), .ch_wr_burst_finish(ch_fin),
    .wr_burst_req(wr_req), .wr_burst_len(wr_len), .wr_burst_addr(wr_addr),
    .wr_burst_data_req(ctl_dreq), .wr_burst_data(wr_data), .wr_burst_finish(ctl_fin),
    .arb_busy(busy), .ch_burst_cnt(bcnt),
    .err_timeout(e_to), .err_len_mismatch(e_lm), .err_len_zero(e_lz)
  );

  always_comb begin
    lenf = '0; addrf = '0; dataf = '0;
    for (int i = 0; i < N; i++) begin
      lenf[i*LW +: LW]  = ch_len[i];
      addrf[i*AW +: AW] = ch_addr[i];
      dataf[i*DW +: DW] = ch_data[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned pick(input logic [N-1:0] m, input int unsigned p);
    for (int unsigned k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_to = '0; m_lm = '0; m_lz = '0;
  endtask

  task automatic check_stats();
    for (int i = 0; i < N; i++) check($sformatf("burst_cnt%0d", i), bcnt[i*32 +: 32], m_cnt[i]);
    check("err_timeout", e_to, m_to);
    check("err_len_mismatch", e_lm, m_lm);
    check("err_len_zero", e_lz, m_lz);
  endtask

  // Raise requests on channels in m that are not yet requesting; fixlen<0 means random length.
  task automatic add_reqs(input logic [N-1:0] m, input int fixlen);
    for (int i = 0; i < N; i++) begin
      if (m[i] && !req[i]) begin
        ch_len[i]  = (fixlen < 0) ? LW'($urandom_range(0, 10)) : LW'(fixlen);
        ch_addr[i] = $urandom;
        ch_data[i] = $urandom;
        req[i]     = 1'b1;
      end
    end
  endtask

  task automatic check_grant(input int unsigned w);
    check("wr_burst_req", wr_req, 1);
    check("wr_burst_len", wr_len, ch_len[w]);
    check("wr_burst_addr", wr_addr, ch_addr[w]);
    check("wr_burst_data", wr_data, ch_data[w]);
  endtask

  // One arbitration round; entered and left at an IDLE negedge.
  // mode: 0 exact beats, 1 one short, 2 one extra, 3 controller silent.
  task automatic run_burst(input int unsigned mode);
    int unsigned  w, beats, cyc;
    logic [N-1:0] oh;
    bit           seen;
    w = pick(req, m_ptr);
    oh = '0; oh[w] = 1'b1;
    @(negedge ddr_clk);
    check("busy_grant", busy, 1);
    if (ch_len[w] == '0) begin
      check("lz_no_req", wr_req, 0);
      check("lz_finish", ch_fin, oh);
      m_lz[w] = 1'b1;
    end else if (mode == 3) begin
      check_grant(w);
      cyc = 0; seen = 0;
      while (!seen && cyc < 100) begin
        @(negedge ddr_clk);
        cyc++;
        seen = (ch_fin != '0);
      end
      check("timeout_cycles", cyc, TO);
      check("timeout_finish", ch_fin, oh);
      m_to[w] = 1'b1;
    end else begin
      check_grant(w);
      beats = ch_len[w];
      if (mode == 1) beats--;
      if (mode == 2) beats++;
      repeat ($urandom_range(0, 3)) @(negedge ddr_clk);
      for (int unsigned b = 0; b < beats; b++) begin
        ctl_dreq = 1'b1;
        #1;
        check("data_req_route", ch_dreq, oh);
        check("beat_data", wr_data, ch_data[w]);
        @(negedge ddr_clk);
        ctl_dreq = 1'b0;
        if (b == 0) check("req_dropped", wr_req, 0);
        if ($urandom_range(0, 1) == 1) @(negedge ddr_clk);
      end
      ctl_fin = 1'b1;
      @(negedge ddr_clk);
      ctl_fin = 1'b0;
      check("finish_pulse", ch_fin, oh);
      m_cnt[w]++;
      if (beats != ch_len[w]) m_lm[w] = 1'b1;
    end
    req[w] = 1'b0;
    m_ptr = (w + 1) % N;
    @(negedge ddr_clk);
    check("back_idle", busy, 0);
    check("finish_cleared", ch_fin, 0);
    check_stats();
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] m;
    int unsigned  md;
    ddr_rst = 1'b1; cfg_rst = 1'b0; req = '0; ctl_dreq = 1'b0; ctl_fin = 1'b0;
    for (int i = 0; i < N; i++) begin ch_len[i] = '0; ch_addr[i] = '0; ch_data[i] = '0; end
    m_ptr = 0;
    model_clear();
    repeat (3) @(negedge ddr_clk);
    check("rst_busy", busy, 0);
    check("rst_wr_req", wr_req, 0);
    check("rst_len", wr_len, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_data", wr_data, 0);
    check("rst_finish", ch_fin, 0);
    check_stats();
    ddr_rst = 1'b0;

    // All channels requesting continuously with len 4: strict rotation.
    for (int t = 0; t < 8; t++) begin
      add_reqs('1, 4);
      run_burst(0);
    end

    // Random traffic with mixed lengths, mismatches and timeouts.
    for (int t = 0; t < 60; t++) begin
      m = N'($urandom_range(0, (1 << N) - 1));
      if ((req | m) == '0) m[$urandom_range(0, N - 1)] = 1'b1;
      add_reqs(m, -1);
      md = $urandom_range(0, 5);
      run_burst(md < 3 ? 0 : md - 2);
    end
    for (int t = 0; t < N && req != '0; t++) run_burst(0);

    // cfg_rst clears statistics only.
    cfg_rst = 1'b1;
    @(negedge ddr_clk);
    cfg_rst = 1'b0;
    model_clear();
    check("cfg_rst_busy", busy, 0);
    check_stats();

    // Zero-length request on channel 0.
    add_reqs(4'b0001, 0);
    run_burst(0);

    // ddr_rst in the middle of a channel 1 burst.
    add_reqs(4'b0010, 8);
    @(negedge ddr_clk);
    check("mid_grant_req", wr_req, 1);
    ctl_dreq = 1'b1;
    repeat (2) @(negedge ddr_clk);
    ctl_dreq = 1'b0;
    ddr_rst = 1'b1;
    req = '0;
    @(negedge ddr_clk);
    ddr_rst = 1'b0;
    m_ptr = 0;
    model_clear();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wr_req", wr_req, 0);
    check("mid_rst_len", wr_len, 0);
    check("mid_rst_data_req", ch_dreq, 0);
    check("mid_rst_finish", ch_fin, 0);
    check_stats();
    add_reqs('1, 4);
    run_burst(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
